mux_8_1_rr_v: RTL and testbench

- Sequential 8:1 collector. It is the gathering end of the 1:8 demux path: 8 source lanes are merged into one registered output stream.
- A round-robin arbiter picks one valid lane per transfer. The winning lane is reported as an 8-bit one-hot select code, in the same format the 1:8 demux consumes. A downstream demux can route the word back by that code.
- Valid/ready handshake on every lane and on the output. One-entry output register.

---
 rtl/mux_pkg_v.sv | 26 ++
 rtl/rr_arbiter_8_v.sv | 43 ++++
 rtl/mux_8_1_rr_v.sv | 77 +++++++
 tb/tb_mux_8_1_rr_v.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mux_pkg_v.sv
// Shared constants and one-hot helpers for the 8:1 round-robin collector.
// The select code uses the same one-hot format that the 1:8 demux consumes.
package mux_pkg_v;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 8;

    function automatic logic [SEL_W-1:0] onehot8(input logic [2:0] idx);
        onehot8 = 8'b0000_0001 << idx;
    endfunction

    // Lowest set bit wins; a zero code maps to index 0.
    function automatic logic [2:0] onehot_to_idx(input logic [SEL_W-1:0] code);
        logic [2:0] v_idx;
        v_idx = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (code[i]) begin
                v_idx = 3'(i);
            end else begin
                v_idx = v_idx;
            end
        end
        onehot_to_idx = v_idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_v.sv
// Combinational 8-way round-robin arbiter.
// The search starts one lane past the last grant and wraps modulo 8.
module rr_arbiter_8_v
    import mux_pkg_v::*;
(
    input  logic [NUM_CH-1:0] i_req,
    input  logic [2:0]        i_last_grant,
    input  logic              i_en,
    output logic [NUM_CH-1:0] o_grant,
    output logic [2:0]        o_idx
);

    logic       w_found;
    logic [2:0] w_cand;
    logic [2:0] w_win;

    // Find the first requesting lane after the last grant.
    always_comb begin
        w_found = 1'b0;
        w_cand  = 3'd0;
        w_win   = 3'd0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_cand = i_last_grant + 3'(i);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Grant only when the output register can take the word.
    always_comb begin
        o_idx = w_win;
        if (i_en && w_found) begin
            o_grant = onehot8(w_win);
        end else begin
            o_grant = 8'h00;
        end
    end

endmodule

// File: rtl/mux_8_1_rr_v.sv
// 8:1 round-robin collector: merges 8 valid/ready lanes into one registered
// output word tagged with the one-hot code of its source lane.
module mux_8_1_rr_v
    import mux_pkg_v::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_CH-1:0]        i_valid,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    output logic [NUM_CH-1:0]        o_ready,
    output logic                     o_valid,
    output logic [DATA_W-1:0]        o_data,
    output logic [SEL_W-1:0]         o_sel_code,
    input  logic                     i_ready
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [SEL_W-1:0]  r_sel;
    logic [2:0]        r_last_grant;

    logic              w_load_en;
    logic              w_arb_en;
    logic [NUM_CH-1:0] w_grant;
    logic [2:0]        w_idx;
    logic [DATA_W-1:0] w_lane_data;

    // The output slot is free when empty or being drained this cycle.
    assign w_load_en = ~r_valid | i_ready;
    assign w_arb_en  = w_load_en & i_rst_n;

    rr_arbiter_8_v u_arb (
        .i_req        (i_valid),
        .i_last_grant (r_last_grant),
        .i_en         (w_arb_en),
        .o_grant      (w_grant),
        .o_idx        (w_idx)
    );

    // Select the winning lane's word.
    always_comb begin
        w_lane_data = i_data[32'(w_idx) * DATA_W +: DATA_W];
    end

    assign o_ready    = w_grant;
    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_sel_code = r_sel;

    // Output register and round-robin pointer; the pointer moves only on a grant.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_sel        <= 8'h00;
            r_last_grant <= 3'd7;
        end else if (|w_grant) begin
            r_valid      <= 1'b1;
            r_data       <= w_lane_data;
            r_sel        <= w_grant;
            r_last_grant <= onehot_to_idx(w_grant);
        end else if (r_valid && i_ready) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_sel        <= 8'h00;
            r_last_grant <= r_last_grant;
        end else begin
            r_valid      <= r_valid;
            r_data       <= r_data;
            r_sel        <= r_sel;
            r_last_grant <= r_last_grant;
        end
    end

endmodule

// File: tb/tb_mux_8_1_rr_v.sv
// Scoreboard bench for mux_8_1_rr_v: directed test-plan phases plus random traffic
// against a queue-based reference model.
module tb_mux_8_1_rr_v;

    localparam int DATA_W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  valid;
    logic [63:0] data;
    logic        ready;
    logic [7:0]  o_ready;
    logic        o_valid;
    logic [7:0]  o_data;
    logic [7:0]  o_sel_code;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] sel;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_last = 7;
    bit   m_valid = 1'b0;

    always #5 clk = ~clk;

    mux_8_1_rr_v #(.DATA_W(DATA_W)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .i_data     (data),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_sel_code (o_sel_code),
        .i_ready    (ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check o_valid/o_ready against the model, advance the model.
    task automatic step(input bit rst, input logic [7:0] v, input bit rdy, input logic [63:0] d);
        int win;
        logic [7:0] exp_ready;
        @(posedge clk);
        #1;
        rst_n = rst; valid = v; ready = rdy; data = d;
        #2;
        chk("o_valid", {63'd0, o_valid}, {63'd0, m_valid});
        win = -1;
        if (rst && (!m_valid || rdy)) begin
            for (int s = 1; s <= 8; s++) begin
                if (win < 0 && v[(m_last + s) % 8]) win = (m_last + s) % 8;
            end
        end
        exp_ready = (win >= 0) ? (8'd1 << win) : 8'd0;
        chk("o_ready", {56'd0, o_ready}, {56'd0, exp_ready});
        if (!rst) begin
            m_valid = 1'b0; m_last = 7; q.delete();
        end else if (win >= 0) begin
            q.push_back('{d: d[win*8 +: 8], sel: exp_ready});
            m_valid = 1'b1; m_last = win;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    function automatic logic [63:0] ramp_data();
        logic [63:0] d;
        for (int k = 0; k < 8; k++) d[k*8 +: 8] = 8'h10 + 8'(k);
        return d;
    endfunction

    function automatic logic [63:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    // Monitor: pops the scoreboard on each output handshake and checks stall stability.
    bit         prev_rst_n = 1'b0;
    bit         prev_valid = 1'b0;
    bit         prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] prev_sel   = 8'h00;
    always @(negedge clk) begin
        exp_t e;
        if (prev_rst_n && prev_valid && !prev_ready) begin
            chk("stall_valid", {63'd0, o_valid}, 64'd1);
            chk("stall_data", {56'd0, o_data}, {56'd0, prev_data});
            chk("stall_sel", {56'd0, o_sel_code}, {56'd0, prev_sel});
        end
        if (o_valid === 1'b0) begin
            chk("idle_sel", {56'd0, o_sel_code}, 64'd0);
            chk("idle_data", {56'd0, o_data}, 64'd0);
        end
        if (o_valid === 1'b1 && ready === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_word", {56'd0, o_sel_code}, 64'd0);
            end else begin
                e = q.pop_front();
                chk("out_data", {56'd0, o_data}, {56'd0, e.d});
                chk("out_sel", {56'd0, o_sel_code}, {56'd0, e.sel});
            end
        end
        prev_rst_n = rst_n; prev_valid = o_valid; prev_ready = ready;
        prev_data = o_data; prev_sel = o_sel_code;
    end

    initial begin
        logic [63:0] d;
        rst_n = 1'b0; valid = 8'hFF; ready = 1'b0; data = 64'd0;

        // Reset hold, then first grant to lane 0, then full round robin.
        step(1'b0, 8'hFF, 1'b0, ramp_data());
        step(1'b0, 8'hFF, 1'b0, ramp_data());
        for (int i = 0; i < 10; i++) step(1'b1, 8'hFF, 1'b1, ramp_data());

        // Sparse requests on lanes 2 and 5.
        step(1'b0, 8'h00, 1'b0, 64'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'b0010_0100, 1'b1, rnd_data());

        // Backpressure on a lane 3 word.
        step(1'b0, 8'h00, 1'b0, 64'd0);
        d = rnd_data();
        d[31:24] = 8'hA5;
        step(1'b1, 8'h08, 1'b1, d);
        for (int i = 0; i < 3; i++) step(1'b1, 8'hFF, 1'b0, rnd_data());
        step(1'b1, 8'hFF, 1'b1, rnd_data());
        step(1'b1, 8'h00, 1'b1, 64'd0);

        // Drain to empty after a single lane 6 word.
        step(1'b0, 8'h00, 1'b0, 64'd0);
        step(1'b1, 8'h40, 1'b1, rnd_data());
        step(1'b1, 8'h00, 1'b1, 64'd0);
        step(1'b1, 8'h00, 1'b1, 64'd0);

        // Reset while stalled on a lane 5 word.
        step(1'b0, 8'h00, 1'b0, 64'd0);
        step(1'b1, 8'h20, 1'b1, rnd_data());
        step(1'b1, 8'h00, 1'b0, 64'd0);
        step(1'b0, 8'hFF, 1'b0, rnd_data());
        step(1'b1, 8'hFF, 1'b1, rnd_data());
        step(1'b1, 8'hFF, 1'b1, rnd_data());

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            bit r;
            r = ($urandom_range(39) != 0);
            step(r, 8'($urandom) & 8'($urandom | $urandom_range(1)), r ? ($urandom_range(3) != 0) : 1'b0, rnd_data());
        end

        for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 1'b1, 64'd0);
        @(posedge clk);
        #3;
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
